// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR configuration sequencer and its staging bank.
package fir_pkg;

  localparam int unsigned DEFAULT_DATA_W        = 8;
  localparam int unsigned DEFAULT_MAX_TAPS      = 16;
  localparam int unsigned DEFAULT_DRAIN_TIMEOUT = 64;
  localparam int unsigned CFG_WORDS             = DEFAULT_MAX_TAPS + 1;
  localparam logic [4:0]  TAP_ADDR              = 5'd0;

  typedef enum logic [2:0] {
    StIdle,
    StRun,
    StDrain,
    StCfgStart,
    StCfgLoad,
    StCfgEnd
  } state_e;

endpackage

// File: rtl/fir_cfg_bank.sv
// Staging register file: word 0 is the tap code, words 1..MAX_TAPS the coefficients.
// Reads of coefficients past the tap code return zero so unused FIR slots are cleared.
module fir_cfg_bank
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned N_WORDS = CFG_WORDS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [4:0]        i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [4:0]        i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_words [N_WORDS];
  logic [4:0]        w_coef_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_WORDS); i++) begin
        r_words[i] <= '0;
      end
    end else if (i_wr_en && (32'(i_wr_addr) < N_WORDS)) begin
      r_words[i_wr_addr] <= i_wr_data;
    end
  end

  always_comb begin
    o_rd_data  = '0;
    w_coef_idx = i_rd_addr - 5'd1;
    if (i_rd_addr == TAP_ADDR) begin
      o_rd_data = r_words[TAP_ADDR];
    end else if ((32'(i_rd_addr) < N_WORDS) &&
                 (32'(w_coef_idx) <= 32'(r_words[TAP_ADDR]))) begin
      o_rd_data = r_words[i_rd_addr];
    end
  end

endmodule

// File: rtl/fir_cfg_sequencer.sv
// Arbitrates the FIR input bus between ADC samples and configuration loads:
// on commit it drains the in-flight sample, streams the staged words, then resumes samples.
module fir_cfg_sequencer
  import fir_pkg::*;
#(
  parameter int unsigned DATA_W        = DEFAULT_DATA_W,
  parameter int unsigned MAX_TAPS      = DEFAULT_MAX_TAPS,
  parameter int unsigned DRAIN_TIMEOUT = DEFAULT_DRAIN_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_cfg_wr_en,
  input  logic [4:0]        i_cfg_wr_addr,
  input  logic [DATA_W-1:0] i_cfg_wr_data,
  input  logic              i_cfg_commit,
  output logic              o_cfg_busy,
  output logic              o_cfg_loaded,
  output logic              o_cfg_done,
  output logic              o_drain_timeout,
  input  logic              i_adc_valid,
  input  logic [DATA_W-1:0] i_adc_data,
  output logic              o_adc_ready,
  output logic [DATA_W-1:0] o_fir_data_in,
  output logic              o_fir_enable,
  output logic              o_fir_configuration,
  output logic              o_fir_config_data_enable,
  input  logic              i_fir_done
);

  localparam int unsigned TmoW    = $clog2(DRAIN_TIMEOUT + 1);
  localparam logic [4:0]  LastIdx = 5'(MAX_TAPS);

  state_e            r_state;
  logic [4:0]        r_idx;
  logic [TmoW-1:0]   r_tmo_cnt;
  logic              r_inflight;
  logic              r_fir_done_q;
  logic              r_cfg_busy;
  logic              r_cfg_loaded;
  logic              r_cfg_done;
  logic              r_drain_timeout;
  logic [DATA_W-1:0] r_fir_data_in;
  logic              r_fir_enable;
  logic              r_fir_configuration;
  logic              r_fir_cde;

  logic              w_adc_ready;
  logic              w_xfer;
  logic              w_done_rise;
  logic [4:0]        w_rd_addr;
  logic [DATA_W-1:0] w_rd_data;

  // Read address runs one word ahead so the registered bus shows word[r_idx].
  assign w_rd_addr   = (r_state == StCfgStart) ? TAP_ADDR : r_idx + 5'd1;
  assign w_adc_ready = (r_state == StRun) && i_fir_done && !r_inflight && !i_cfg_commit;
  assign w_xfer      = w_adc_ready && i_adc_valid;
  assign w_done_rise = i_fir_done && !r_fir_done_q;

  fir_cfg_bank #(
    .DATA_W  (DATA_W),
    .N_WORDS (MAX_TAPS + 1)
  ) u_bank (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (i_cfg_wr_en && !r_cfg_busy),
    .i_wr_addr (i_cfg_wr_addr),
    .i_wr_data (i_cfg_wr_data),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state             <= StIdle;
      r_idx               <= '0;
      r_tmo_cnt           <= '0;
      r_inflight          <= 1'b0;
      r_fir_done_q        <= 1'b0;
      r_cfg_busy          <= 1'b0;
      r_cfg_loaded        <= 1'b0;
      r_cfg_done          <= 1'b0;
      r_drain_timeout     <= 1'b0;
      r_fir_data_in       <= '0;
      r_fir_enable        <= 1'b0;
      r_fir_configuration <= 1'b0;
      r_fir_cde           <= 1'b0;
    end else begin
      r_fir_done_q        <= i_fir_done;
      r_fir_enable        <= 1'b0;
      r_fir_configuration <= 1'b0;
      r_fir_cde           <= 1'b0;
      r_cfg_done          <= 1'b0;

      if (w_done_rise) begin
        r_inflight <= 1'b0;
      end
      if (w_xfer) begin
        r_inflight    <= 1'b1;
        r_fir_enable  <= 1'b1;
        r_fir_data_in <= i_adc_data;
      end

      unique case (r_state)
        StIdle, StRun: begin
          if (i_cfg_commit) begin
            r_state         <= StDrain;
            r_cfg_busy      <= 1'b1;
            r_tmo_cnt       <= '0;
            r_drain_timeout <= 1'b0;
          end
        end
        StDrain: begin
          if (!r_inflight) begin
            r_state             <= StCfgStart;
            r_fir_configuration <= 1'b1;
          end else if (r_tmo_cnt == TmoW'(DRAIN_TIMEOUT)) begin
            // FIR never reported completion: abandon the sample and load anyway.
            r_drain_timeout     <= 1'b1;
            r_inflight          <= 1'b0;
            r_state             <= StCfgStart;
            r_fir_configuration <= 1'b1;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        StCfgStart: begin
          r_state       <= StCfgLoad;
          r_idx         <= '0;
          r_fir_cde     <= 1'b1;
          r_fir_data_in <= w_rd_data;
        end
        StCfgLoad: begin
          if (r_idx == LastIdx) begin
            r_state    <= StCfgEnd;
            r_cfg_done <= 1'b1;
          end else begin
            r_idx         <= r_idx + 5'd1;
            r_fir_cde     <= 1'b1;
            r_fir_data_in <= w_rd_data;
          end
        end
        StCfgEnd: begin
          r_state      <= StRun;
          r_cfg_busy   <= 1'b0;
          r_cfg_loaded <= 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cfg_busy               = r_cfg_busy;
  assign o_cfg_loaded             = r_cfg_loaded;
  assign o_cfg_done               = r_cfg_done;
  assign o_drain_timeout          = r_drain_timeout;
  assign o_adc_ready              = w_adc_ready;
  assign o_fir_data_in            = r_fir_data_in;
  assign o_fir_enable             = r_fir_enable;
  assign o_fir_configuration      = r_fir_configuration;
  assign o_fir_config_data_enable = r_fir_cde;

endmodule

// File: tb/tb_fir_cfg_sequencer.sv
// Self-checking bench for fir_cfg_sequencer: directed scenarios plus random sample traffic
// against a behavioural model of the staging bank and sample handshake.
module tb_fir_cfg_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cfg_wr_en = 1'b0;
  logic [4:0] cfg_wr_addr = '0;
  logic [7:0] cfg_wr_data = '0;
  logic       cfg_commit = 1'b0;
  logic       cfg_busy, cfg_loaded, cfg_done, drain_timeout;
  logic       adc_valid = 1'b0;
  logic [7:0] adc_data = '0;
  logic       adc_ready;
  logic [7:0] fir_data_in;
  logic       fir_enable, fir_configuration, fir_config_data_enable;
  logic       fir_done = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] m_bank [17];

  always #5 clk = ~clk;

  fir_cfg_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .i_cfg_wr_en              (cfg_wr_en),
    .i_cfg_wr_addr            (cfg_wr_addr),
    .i_cfg_wr_data            (cfg_wr_data),
    .i_cfg_commit             (cfg_commit),
    .o_cfg_busy               (cfg_busy),
    .o_cfg_loaded             (cfg_loaded),
    .o_cfg_done               (cfg_done),
    .o_drain_timeout          (drain_timeout),
    .i_adc_valid              (adc_valid),
    .i_adc_data               (adc_data),
    .o_adc_ready              (adc_ready),
    .o_fir_data_in            (fir_data_in),
    .o_fir_enable             (fir_enable),
    .o_fir_configuration      (fir_configuration),
    .o_fir_config_data_enable (fir_config_data_enable),
    .i_fir_done               (fir_done)
  );

  // Word the FIR should receive at load position i, derived from the staged values.
  function automatic logic [7:0] exp_word(input int i);
    if (i == 0) return m_bank[0];
    if ((i - 1) <= int'(m_bank[0])) return m_bank[i];
    return 8'h00;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic bank_write(input logic [4:0] a, input logic [7:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    if (a <= 5'd16) m_bank[a] = d;
    cyc();
    cfg_wr_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fir_done = 1'b1; adc_valid = 1'b1; adc_data = 8'hA5;
    repeat (3) cyc();
    for (int i = 0; i < 17; i++) m_bank[i] = 8'h00;
    n_vec++;
    if ({cfg_busy, cfg_loaded, cfg_done, drain_timeout, adc_ready, fir_enable,
         fir_configuration, fir_config_data_enable, fir_data_in} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_outputs: got busy%b ld%b dn%b to%b rdy%b en%b cfg%b cde%b d=%h, want all 0",
               cfg_busy, cfg_loaded, cfg_done, drain_timeout, adc_ready, fir_enable,
               fir_configuration, fir_config_data_enable, fir_data_in);
    end
    rst_n = 1'b1;
    cyc();
    n_vec++;
    if (adc_ready !== 1'b0 || fir_enable !== 1'b0) begin
      n_err++;
      $display("FAIL idle_no_accept: got rdy=%b en=%b, want 0 0", adc_ready, fir_enable);
    end
    adc_valid = 1'b0;
  endtask

  task automatic test_load();
    logic [7:0] tap, last;
    for (int it = 0; it < 4; it++) begin
      tap = (it == 0) ? 8'd3 : 8'($urandom_range(0, 15));
      bank_write(5'd0, tap);
      for (int k = 0; k < 15; k++)
        bank_write(5'(k + 1), (it == 0) ? 8'(8'h11 + k) : 8'($urandom_range(0, 255)));
      bank_write(5'($urandom_range(17, 31)), 8'hFF);
      // Final coefficient written in the same cycle as the commit.
      last = (it == 0) ? 8'h20 : 8'($urandom_range(0, 255));
      cfg_wr_en = 1'b1; cfg_wr_addr = 5'd16; cfg_wr_data = last; cfg_commit = 1'b1;
      m_bank[16] = last;
      cyc();
      cfg_wr_en = 1'b0; cfg_commit = 1'b0;
      n_vec++;
      if (cfg_busy !== 1'b1 || fir_configuration !== 1'b0) begin
        n_err++;
        $display("FAIL load%0d_drain: got busy=%b cfg=%b, want 1 0", it, cfg_busy, fir_configuration);
      end
      cyc();
      n_vec++;
      if (fir_configuration !== 1'b1 || fir_config_data_enable !== 1'b0) begin
        n_err++;
        $display("FAIL load%0d_cfg_pulse: got cfg=%b cde=%b, want 1 0", it, fir_configuration,
                 fir_config_data_enable);
      end
      for (int i = 0; i < 17; i++) begin
        cyc();
        n_vec++;
        if (fir_config_data_enable !== 1'b1 || fir_data_in !== exp_word(i) ||
            fir_configuration !== 1'b0 || fir_enable !== 1'b0) begin
          n_err++;
          $display("FAIL load%0d_word%0d: got cde=%b d=%h cfg=%b en=%b, want 1 %h 0 0", it, i,
                   fir_config_data_enable, fir_data_in, fir_configuration, fir_enable, exp_word(i));
        end
      end
      cyc();
      n_vec++;
      if (cfg_done !== 1'b1 || fir_config_data_enable !== 1'b0 || cfg_busy !== 1'b1) begin
        n_err++;
        $display("FAIL load%0d_done: got done=%b cde=%b busy=%b, want 1 0 1", it, cfg_done,
                 fir_config_data_enable, cfg_busy);
      end
      cyc();
      n_vec++;
      if (cfg_done !== 1'b0 || cfg_busy !== 1'b0 || cfg_loaded !== 1'b1 || adc_ready !== 1'b1) begin
        n_err++;
        $display("FAIL load%0d_resume: got done=%b busy=%b ld=%b rdy=%b, want 0 0 1 1", it,
                 cfg_done, cfg_busy, cfg_loaded, adc_ready);
      end
    end
  endtask

  task automatic test_sample();
    fir_done = 1'b1; adc_valid = 1'b1; adc_data = 8'h5A;
    #1;
    n_vec++;
    if (adc_ready !== 1'b1) begin
      n_err++; $display("FAIL sample_ready: got %b want 1", adc_ready);
    end
    cyc();
    n_vec++;
    if (fir_enable !== 1'b1 || fir_data_in !== 8'h5A) begin
      n_err++; $display("FAIL sample_strobe: got en=%b d=%h, want 1 5a", fir_enable, fir_data_in);
    end
    adc_data = 8'h33;
    #1;
    n_vec++;
    if (adc_ready !== 1'b0) begin
      n_err++; $display("FAIL sample_inflight_ready: got %b want 0", adc_ready);
    end
    cyc();
    n_vec++;
    if (fir_enable !== 1'b0 || fir_data_in !== 8'h5A) begin
      n_err++; $display("FAIL sample_hold: got en=%b d=%h, want 0 5a", fir_enable, fir_data_in);
    end
    fir_done = 1'b0;
    cyc();
    fir_done = 1'b1;
    #1;
    n_vec++;
    if (adc_ready !== 1'b0) begin
      n_err++; $display("FAIL sample_rise_unsampled: got rdy=%b want 0", adc_ready);
    end
    cyc();
    n_vec++;
    if (adc_ready !== 1'b1 || fir_enable !== 1'b0) begin
      n_err++; $display("FAIL sample_rearm: got rdy=%b en=%b, want 1 0", adc_ready, fir_enable);
    end
    // Commit and a valid sample together: commit wins.
    cfg_commit = 1'b1;
    #1;
    n_vec++;
    if (adc_ready !== 1'b0) begin
      n_err++; $display("FAIL commit_priority_ready: got %b want 0", adc_ready);
    end
    cyc();
    cfg_commit = 1'b0; adc_valid = 1'b0;
    n_vec++;
    if (fir_enable !== 1'b0 || cfg_busy !== 1'b1) begin
      n_err++; $display("FAIL commit_priority: got en=%b busy=%b, want 0 1", fir_enable, cfg_busy);
    end
    repeat (20) cyc();
    n_vec++;
    if (cfg_busy !== 1'b0 || fir_data_in !== exp_word(16)) begin
      n_err++;
      $display("FAIL commit_priority_end: got busy=%b d=%h, want 0 %h", cfg_busy, fir_data_in,
               exp_word(16));
    end
  endtask

  task automatic test_commit_inflight();
    int ncde, nen;
    fir_done = 1'b1; adc_valid = 1'b1; adc_data = 8'($urandom);
    cyc();
    adc_valid = 1'b0; fir_done = 1'b0;
    cyc();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0; adc_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      cyc();
      n_vec++;
      if (fir_configuration !== 1'b0) begin
        n_err++; $display("FAIL drain_wait%0d: got cfg=%b want 0", k, fir_configuration);
      end
    end
    fir_done = 1'b1;
    cyc();
    n_vec++;
    if (fir_configuration !== 1'b0) begin
      n_err++; $display("FAIL drain_rise_edge: got cfg=%b want 0", fir_configuration);
    end
    cyc();
    n_vec++;
    if (fir_configuration !== 1'b1) begin
      n_err++; $display("FAIL drain_exit: got cfg=%b want 1", fir_configuration);
    end
    ncde = 0; nen = 0;
    repeat (18) begin
      cyc();
      ncde += int'(fir_config_data_enable);
      nen  += int'(fir_enable);
    end
    adc_valid = 1'b0;
    n_vec++;
    if (ncde != 17 || nen != 0 || cfg_done !== 1'b1) begin
      n_err++;
      $display("FAIL inflight_load: got cde_cycles=%0d en_cycles=%0d done=%b, want 17 0 1",
               ncde, nen, cfg_done);
    end
    cyc();
  endtask

  task automatic test_timeout();
    int n;
    bit seen;
    fir_done = 1'b1; adc_valid = 1'b1; adc_data = 8'($urandom);
    cyc();
    adc_valid = 1'b0; fir_done = 1'b0;
    cyc();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    n = 0; seen = 1'b0;
    while (n < 100 && !seen) begin
      cyc();
      n++;
      if (n == 60) begin
        n_vec++;
        if (drain_timeout !== 1'b0) begin
          n_err++; $display("FAIL timeout_early: got to=%b at 60, want 0", drain_timeout);
        end
      end
      if (fir_configuration === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen || n < 64 || n > 66 || drain_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_fire: got seen=%b cycles=%0d to=%b, want 1 64..66 1", seen, n,
               drain_timeout);
    end
    repeat (19) cyc();
    n_vec++;
    if (cfg_busy !== 1'b0 || cfg_loaded !== 1'b1 || drain_timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_sticky: got busy=%b ld=%b to=%b, want 0 1 1", cfg_busy, cfg_loaded,
               drain_timeout);
    end
    fir_done = 1'b1;
    cyc();
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    n_vec++;
    if (drain_timeout !== 1'b0) begin
      n_err++; $display("FAIL timeout_clear: got to=%b want 0", drain_timeout);
    end
    repeat (20) cyc();
    n_vec++;
    if (cfg_busy !== 1'b0) begin
      n_err++; $display("FAIL timeout_reload: got busy=%b want 0", cfg_busy);
    end
  endtask

  task automatic test_busy_ignore();
    int extra;
    bank_write(5'd0, 8'($urandom_range(8, 15)));
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    cyc();
    for (int i = 0; i < 17; i++) begin
      cyc();
      cfg_wr_en = 1'b0; cfg_commit = 1'b0;
      n_vec++;
      if (fir_config_data_enable !== 1'b1 || fir_data_in !== exp_word(i)) begin
        n_err++;
        $display("FAIL busy_word%0d: got cde=%b d=%h, want 1 %h", i, fir_config_data_enable,
                 fir_data_in, exp_word(i));
      end
      if (i == 1) begin
        cfg_wr_en = 1'b1; cfg_wr_addr = 5'd5; cfg_wr_data = ~m_bank[5];
      end
      if (i == 6) cfg_commit = 1'b1;
    end
    cyc();
    cyc();
    extra = 0;
    repeat (25) begin
      cyc();
      if (fir_configuration === 1'b1 || cfg_busy === 1'b1) extra++;
    end
    n_vec++;
    if (extra != 0) begin
      n_err++; $display("FAIL busy_no_requeue: got %0d busy/cfg cycles, want 0", extra);
    end
  endtask

  task automatic test_reset_midload();
    int bad;
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    cyc();
    for (int i = 0; i <= 8; i++) cyc();
    rst_n = 1'b0; adc_valid = 1'b1;
    cyc();
    n_vec++;
    if ({fir_enable, fir_configuration, fir_config_data_enable, cfg_done, cfg_loaded,
         cfg_busy, adc_ready} !== 7'b0) begin
      n_err++;
      $display("FAIL midload_reset: got en%b cfg%b cde%b dn%b ld%b busy%b rdy%b, want all 0",
               fir_enable, fir_configuration, fir_config_data_enable, cfg_done, cfg_loaded,
               cfg_busy, adc_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) m_bank[i] = 8'h00;
    bad = 0;
    repeat (5) begin
      cyc();
      if (adc_ready !== 1'b0 || fir_enable !== 1'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL midload_idle: got %0d accepting cycles, want 0", bad);
    end
    adc_valid = 1'b0;
    cfg_commit = 1'b1;
    cyc();
    cfg_commit = 1'b0;
    repeat (20) cyc();
    n_vec++;
    if (cfg_loaded !== 1'b1 || cfg_busy !== 1'b0 || adc_ready !== 1'b1 ||
        fir_data_in !== exp_word(16)) begin
      n_err++;
      $display("FAIL midload_recover: got ld=%b busy=%b rdy=%b d=%h, want 1 0 1 %h", cfg_loaded,
               cfg_busy, adc_ready, fir_data_in, exp_word(16));
    end
  endtask

  task automatic test_random_traffic();
    bit m_inflight, m_prev, exp_ready, xfer, v, d;
    logic [7:0] m_last, s;
    m_inflight = 1'b0; m_prev = fir_done; m_last = exp_word(16);
    for (int c = 0; c < 400; c++) begin
      v = 1'($urandom_range(0, 1));
      d = ($urandom_range(0, 2) != 0);
      s = 8'($urandom);
      adc_valid = v; fir_done = d; adc_data = s;
      #1;
      exp_ready = d && !m_inflight;
      n_vec++;
      if (adc_ready !== exp_ready) begin
        n_err++; $display("FAIL rand%0d_ready: got %b want %b", c, adc_ready, exp_ready);
      end
      xfer = v && exp_ready;
      cyc();
      if (xfer) m_last = s;
      n_vec++;
      if (fir_enable !== xfer || fir_data_in !== m_last) begin
        n_err++;
        $display("FAIL rand%0d_out: got en=%b d=%h, want %b %h", c, fir_enable, fir_data_in,
                 xfer, m_last);
      end
      if (xfer) m_inflight = 1'b1;
      else if (d && !m_prev) m_inflight = 1'b0;
      m_prev = d;
    end
    adc_valid = 1'b0; fir_done = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_load();
    test_sample();
    test_commit_inflight();
    test_timeout();
    test_busy_ignore();
    test_reset_midload();
    test_random_traffic();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
